// File: rtl/pc_fetch_ctrl.sv
// PC/fetch sequencer: IDLE->REQ (hold req/addr until ack)->HOLD (inst to consumer)->next PC; misaligned NPC halts.
// Defining PC_JR_EN enables the register jump (npc_op=11 -> npc_rs) and with it the misalignment trap.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        inst_ready,
  input  logic        npc_valid,
  input  logic [1:0]  npc_op,
  input  logic [25:0] npc_imm,
  input  logic [31:0] npc_rs,
  output logic [31:0] pc_out,
  output logic [31:0] retire_cnt,
  output logic        misalign_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_HALT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic [31:0] r_retire;
  logic        r_err;

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_npc;
  logic        w_misalign;
  logic        w_adv;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{npc_imm[15]}}, npc_imm[15:0], 2'b00};
  assign w_adv    = (r_state == S_HOLD) && inst_ready && npc_valid && !stall;

  always_comb begin
    w_npc = w_pc4;
    case (npc_op)
      2'b01:   w_npc = w_pc4 + w_br_off;
      2'b10:   w_npc = {w_pc4[31:28], npc_imm, 2'b00};
`ifdef PC_JR_EN
      2'b11:   w_npc = npc_rs;
`endif
      default: w_npc = w_pc4;
    endcase
  end

`ifdef PC_JR_EN
  assign w_misalign = (w_npc[1:0] != 2'b00);
`else
  // Every non-JR target is word-aligned by construction, so the trap cannot fire.
  logic w_unused_rs;
  assign w_unused_rs = ^npc_rs;
  assign w_misalign  = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (!stall) w_state_nxt = S_REQ;
      S_REQ:  if (imem_ack) w_state_nxt = S_HOLD;
      S_HOLD: if (w_adv) w_state_nxt = w_misalign ? S_HALT : S_REQ;
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= RESET_PC;
      r_inst   <= 32'd0;
      r_retire <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_REQ) && imem_ack) r_inst <= imem_rdata;
      if (w_adv && !w_misalign) begin
        r_pc     <= w_npc;
        r_retire <= r_retire + 32'd1;
      end
      if (w_adv && w_misalign) r_err <= 1'b1;
    end
  end

  assign imem_req     = (r_state == S_REQ);
  assign inst_valid   = (r_state == S_HOLD);
  assign imem_addr    = r_pc;
  assign pc_out       = r_pc;
  assign inst         = r_inst;
  assign retire_cnt   = r_retire;
  assign misalign_err = r_err;

endmodule
